// File: rtl/tristate_bus_arbiter_if.sv
// Bus-side signals of the tri-state arbiter, grouped for the requester
// (master) and arbiter (slave) ends.
interface tristate_bus_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] lock_i;
  logic [N_REQ-1:0] oe_o;
  logic [OW-1:0]    owner_o;
  logic             busy_o;
  logic             turn_o;

  modport master (
    output req_i, lock_i,
    input  oe_o, owner_o, busy_o, turn_o
  );

  modport slave (
    input  req_i, lock_i,
    output oe_o, owner_o, busy_o, turn_o
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for one shared tri-state line. oe_o is one-hot or zero
// and drives bufif1 controls directly; owners are separated by TURN_CYCLES
// all-off cycles and each tenure is capped at HOLD_MAX cycles.
// Optional macro TRI_ARB_LOCK_EN: lock_i[owner] extends a tenure past
// HOLD_MAX until lock or request drops.
module tristate_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_MAX    = 8,
  parameter int TURN_CYCLES = 1
) (
  input logic                   clk_i,
  input logic                   rst_i,
  tristate_bus_arbiter_if.slave bus
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t           r_state;
  logic [TW-1:0]    r_tenure;
  logic [CW-1:0]    r_turnCnt;
  logic [N_REQ-1:0] r_oe;
  logic [OW-1:0]    r_owner;
  logic             r_busy;
  logic             r_turn;

  logic [OW-1:0]    w_cand;
  logic [OW-1:0]    w_winner;
  logic [N_REQ-1:0] w_winnerOh;
  logic             w_anyReq;
  logic             w_lockOwner;
  logic             w_release;

  // Round-robin pick: scan from owner+1 upward, the current owner is tried last
  always_comb begin
    w_cand     = r_owner;
    w_winner   = r_owner;
    w_winnerOh = '0;
    w_anyReq   = |bus.req_i;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = OW'((int'(r_owner) + k) % N_REQ);
      if (bus.req_i[w_cand]) w_winner = w_cand;
    end
    w_winnerOh[w_winner] = 1'b1;
  end

  // Release decision for the current owner; lock only matters in the lock build
  always_comb begin
`ifdef TRI_ARB_LOCK_EN
    w_lockOwner = bus.lock_i[r_owner];
`else
    w_lockOwner = 1'b0 & bus.lock_i[r_owner];
`endif
    w_release = !bus.req_i[r_owner] ||
                ((r_tenure >= TW'(HOLD_MAX)) && !w_lockOwner);
  end

  // Arbitration FSM with registered enables, owner, busy and turnaround flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_tenure  <= '0;
      r_turnCnt <= '0;
      r_oe      <= '0;
      r_owner   <= OW'(N_REQ - 1);
      r_busy    <= 1'b0;
      r_turn    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state  <= GRANT;
            r_oe     <= w_winnerOh;
            r_owner  <= w_winner;
            r_tenure <= TW'(1);
            r_busy   <= 1'b1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state   <= TURN;
            r_oe      <= '0;
            r_busy    <= 1'b0;
            r_turn    <= 1'b1;
            r_turnCnt <= CW'(1);
          end else if (r_tenure != TW'(HOLD_MAX)) begin
            r_tenure <= r_tenure + TW'(1);
          end
        end
        TURN: begin
          if (r_turnCnt == CW'(TURN_CYCLES)) begin
            r_turn    <= 1'b0;
            r_turnCnt <= '0;
            if (w_anyReq) begin
              r_state  <= GRANT;
              r_oe     <= w_winnerOh;
              r_owner  <= w_winner;
              r_tenure <= TW'(1);
              r_busy   <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_turnCnt <= r_turnCnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_oe    <= '0;
          r_busy  <= 1'b0;
          r_turn  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oe_o    = r_oe;
  assign bus.owner_o = r_owner;
  assign bus.busy_o  = r_busy;
  assign bus.turn_o  = r_turn;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Testbench for tristate_bus_arbiter: two instances (TURN_CYCLES=1 and 2)
// checked against a cycle-level behavioural model of grants, tenure and gaps.
module tb_tristate_bus_arbiter;

`ifdef TRI_ARB_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  typedef struct {
    int owner;
    bit on;
    int held;
    int gap;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCompared = 0;
  int   nMismatched = 0;
  model_t m1, m2;

  tristate_bus_arbiter_if #(.N_REQ(4)) bus1 ();
  tristate_bus_arbiter_if #(.N_REQ(4)) bus2 ();

  tristate_bus_arbiter #(.N_REQ(4), .HOLD_MAX(8), .TURN_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1));
  tristate_bus_arbiter #(.N_REQ(4), .HOLD_MAX(8), .TURN_CYCLES(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2));

  always #5 clk = ~clk;

  // Next model state from the rules: hold up to 8 cycles, gap of turnCycles,
  // then the next requester after the previous owner wins.
  function automatic model_t modelStep(model_t m, logic [3:0] req, logic [3:0] lock,
                                       logic r, int turnCycles);
    model_t n = m;
    bit lockBit;
    bit found;
    if (r) begin
      n.owner = 3; n.on = 0; n.held = 0; n.gap = 0;
      return n;
    end
    if (m.on) begin
      lockBit = lock[m.owner] && LOCK_BUILD;
      if (!req[m.owner] || (m.held >= 8 && !lockBit)) begin
        n.on = 0; n.gap = 1;
      end else if (m.held < 8) begin
        n.held = m.held + 1;
      end
      return n;
    end
    if (m.gap > 0 && m.gap < turnCycles) begin
      n.gap = m.gap + 1;
      return n;
    end
    n.gap = 0;
    found = 0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[(m.owner + k) % 4]) begin
        found = 1;
        n.owner = (m.owner + k) % 4;
      end
    end
    if (found) begin
      n.on = 1; n.held = 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] expOut(model_t m);
    logic [3:0] oe;
    oe = m.on ? 4'(1 << m.owner) : 4'b0000;
    return {oe, 2'(m.owner), m.on, (m.gap > 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    m1 = modelStep(m1, bus1.req_i, bus1.lock_i, rst, 1);
    m2 = modelStep(m2, bus2.req_i, bus2.lock_i, rst, 2);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock);
    bus1.req_i  = req;
    bus1.lock_i = lock;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    bus2.req_i = 4'b0000;
    bus2.lock_i = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    tick();
    nCompared++;
    if ({bus1.oe_o, bus1.owner_o, bus1.busy_o, bus1.turn_o} !== 8'b0000_11_0_0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state got %b want %b",
               {bus1.oe_o, bus1.owner_o, bus1.busy_o, bus1.turn_o}, 8'b0000_11_0_0);
    end
  endtask

  task automatic test_single();
    logic [3:0] want;
    doReset();
    applyStimulus(4'b0100, 4'b0000);
    for (int i = 1; i <= 27; i++) begin
      tick();
      want = (i % 9 != 0) ? 4'b0100 : 4'b0000;
      nCompared++;
      if (bus1.oe_o !== want || bus1.turn_o !== (i % 9 == 0) ||
          (want != 0 && bus1.owner_o !== 2'd2)) begin
        nMismatched++;
        $display("[TB] FAIL single cyc=%0d got oe=%b turn=%b owner=%0d want oe=%b turn=%b owner=2",
                 i, bus1.oe_o, bus1.turn_o, bus1.owner_o, want, (i % 9 == 0));
      end
      nCompared++;
      if ({bus1.oe_o, bus1.owner_o, bus1.busy_o, bus1.turn_o} !== expOut(m1)) begin
        nMismatched++;
        $display("[TB] FAIL single_model cyc=%0d got %b want %b", i,
                 {bus1.oe_o, bus1.owner_o, bus1.busy_o, bus1.turn_o}, expOut(m1));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    doReset();
    applyStimulus(4'b1111, 4'b0000);
    for (int i = 1; i <= 40; i++) begin
      tick();
      want = (i % 9 == 0) ? 4'b0000 : 4'(1 << (((i - 1) / 9) % 4));
      nCompared++;
      if (bus1.oe_o !== want || bus1.turn_o !== (i % 9 == 0)) begin
        nMismatched++;
        $display("[TB] FAIL round_robin cyc=%0d got oe=%b turn=%b want oe=%b turn=%b",
                 i, bus1.oe_o, bus1.turn_o, want, (i % 9 == 0));
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] wantSeq [5];
    wantSeq = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
    doReset();
    applyStimulus(4'b0010, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) applyStimulus(4'b1010, 4'b0000);
      if (i == 2) applyStimulus(4'b1000, 4'b0000);
      nCompared++;
      if (bus1.oe_o !== wantSeq[i] ||
          {bus1.oe_o, bus1.owner_o, bus1.busy_o, bus1.turn_o} !== expOut(m1)) begin
        nMismatched++;
        $display("[TB] FAIL early_release step=%0d got oe=%b all=%b want oe=%b all=%b", i,
                 bus1.oe_o, {bus1.oe_o, bus1.owner_o, bus1.busy_o, bus1.turn_o},
                 wantSeq[i], expOut(m1));
      end
    end
  endtask

  task automatic test_pulse();
    logic [3:0] wantSeq [3];
    logic       turnSeq [3];
    wantSeq = '{4'b0001, 4'b0000, 4'b0000};
    turnSeq = '{1'b0, 1'b1, 1'b0};
    doReset();
    applyStimulus(4'b0001, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(4'b0000, 4'b0000);
      nCompared++;
      if (bus1.oe_o !== wantSeq[i] || bus1.turn_o !== turnSeq[i]) begin
        nMismatched++;
        $display("[TB] FAIL pulse step=%0d got oe=%b turn=%b want oe=%b turn=%b",
                 i, bus1.oe_o, bus1.turn_o, wantSeq[i], turnSeq[i]);
      end
    end
  endtask

  task automatic test_lock();
    int relCyc;
    relCyc = LOCK_BUILD ? 21 : 9;
    doReset();
    applyStimulus(4'b0011, 4'b0001);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 20) applyStimulus(4'b0011, 4'b0000);
      nCompared++;
      if ({bus1.oe_o, bus1.owner_o, bus1.busy_o, bus1.turn_o} !== expOut(m1)) begin
        nMismatched++;
        $display("[TB] FAIL lock_model cyc=%0d got %b want %b", i,
                 {bus1.oe_o, bus1.owner_o, bus1.busy_o, bus1.turn_o}, expOut(m1));
      end
      if (i == relCyc - 1 || i == relCyc || i == relCyc + 1) begin
        nCompared++;
        if (bus1.oe_o !== ((i == relCyc - 1) ? 4'b0001 : (i == relCyc) ? 4'b0000 : 4'b0010)) begin
          nMismatched++;
          $display("[TB] FAIL lock_release cyc=%0d got oe=%b want %b", i, bus1.oe_o,
                   (i == relCyc - 1) ? 4'b0001 : (i == relCyc) ? 4'b0000 : 4'b0010);
        end
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    int  run;
    bit  hit;
    run = 0;
    hit = 0;
    doReset();
    applyStimulus(4'b1111, 4'b0000);
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      run = (bus1.oe_o == 4'b0100) ? run + 1 : 0;
      if (run == 4) hit = 1;
    end
    nCompared++;
    if (!hit) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_wait got no 4th cycle of owner 2 want one within 60 cycles");
    end
    rst = 1'b1;
    tick();
    nCompared++;
    if (bus1.oe_o !== 4'b0000 || bus1.owner_o !== 2'd3 || bus1.turn_o !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid got oe=%b owner=%0d turn=%b want oe=0000 owner=3 turn=0",
               bus1.oe_o, bus1.owner_o, bus1.turn_o);
    end
    rst = 1'b0;
    tick();
    nCompared++;
    if (bus1.oe_o !== 4'b0001 || bus1.owner_o !== 2'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_regrant got oe=%b owner=%0d want oe=0001 owner=0",
               bus1.oe_o, bus1.owner_o);
    end
  endtask

  task automatic test_random_no_overlap();
    logic [3:0] prevOe;
    int         zeroRun;
    bit         seenGrant;
    prevOe = 0;
    zeroRun = 0;
    seenGrant = 0;
    doReset();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 2) == 0) bus2.req_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus2.lock_i = 4'($urandom_range(0, 15));
      tick();
      nCompared++;
      if ({bus2.oe_o, bus2.owner_o, bus2.busy_o, bus2.turn_o} !== expOut(m2)) begin
        nMismatched++;
        $display("[TB] FAIL random_model cyc=%0d got %b want %b", i,
                 {bus2.oe_o, bus2.owner_o, bus2.busy_o, bus2.turn_o}, expOut(m2));
      end
      nCompared++;
      if (!$onehot0(bus2.oe_o)) begin
        nMismatched++;
        $display("[TB] FAIL random_onehot cyc=%0d got oe=%b want zero or one-hot", i, bus2.oe_o);
      end
      if (bus2.oe_o != 0) begin
        if (prevOe == 0 && seenGrant) begin
          nCompared++;
          if (zeroRun < 2) begin
            nMismatched++;
            $display("[TB] FAIL random_gap cyc=%0d got gap=%0d want >=2", i, zeroRun);
          end
        end
        if (prevOe != 0) begin
          nCompared++;
          if (prevOe !== bus2.oe_o) begin
            nMismatched++;
            $display("[TB] FAIL random_overlap cyc=%0d got oe %b->%b want same owner or gap",
                     i, prevOe, bus2.oe_o);
          end
        end
        seenGrant = 1;
        zeroRun = 0;
      end else begin
        zeroRun++;
      end
      prevOe = bus2.oe_o;
    end
  endtask

  task automatic checkOutput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
  endtask

  initial begin
    m1 = '{owner: 3, on: 0, held: 0, gap: 0};
    m2 = '{owner: 3, on: 0, held: 0, gap: 0};
    applyStimulus(4'b0000, 4'b0000);
    bus2.req_i = 4'b0000;
    bus2.lock_i = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_pulse();
    test_lock();
    test_reset_mid_grant();
    test_random_no_overlap();
    checkOutput();
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
